// File: rtl/cb_piso_tx.sv
// Parallel-in serial-out transmitter with SOF/EOF framing and an optional
// even-parity trailer. A new word may be taken on the last bit of a frame.
module cb_piso_tx #(
   parameter int WIDTH     = 8,
   parameter int MSB_FIRST = 1,
   parameter int PARITY    = 0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic [WIDTH-1:0] din,
   input  logic             load_valid,
   output logic             load_ready,
   output logic             sout,
   output logic             sout_valid,
   output logic             sof,
   output logic             eof,
   output logic             busy
);

   localparam int FLEN = WIDTH + PARITY;
   localparam int CW   = (FLEN > 1) ? $clog2(FLEN) : 1;
   localparam logic [CW-1:0] LAST = CW'(FLEN - 1);

   typedef enum logic {
      IDLE,
      SHIFT
   } state_t;

   state_t           state, state_n;
   logic [WIDTH-1:0] sreg, sreg_n;
   logic [CW-1:0]    cnt, cnt_n;
   logic [CW-1:0]    cnt_inc;
   logic             par, par_n;
   logic             sout_n;
   logic             sv_n;
   logic             sof_n;
   logic             eof_n;

   logic             last;
   logic             accept;
   logic             first_bit;
   logic [WIDTH-1:0] load_word;
   logic             next_bit;
   logic [WIDTH-1:0] shifted;

   assign last    = (state == SHIFT) && (cnt == LAST);
   assign cnt_inc = cnt + CW'(1);

   assign load_ready = en && ((state == IDLE) || last);
   assign accept     = load_valid && load_ready;
   assign busy       = (state == SHIFT);

   // The register keeps only the not-yet-sent bits, so the
   // outgoing bit always sits at one fixed end.
   assign first_bit = (MSB_FIRST != 0) ? din[WIDTH-1] : din[0];
   assign load_word = (MSB_FIRST != 0) ? (din << 1) : (din >> 1);
   assign next_bit  = (MSB_FIRST != 0) ? sreg[WIDTH-1] : sreg[0];
   assign shifted   = (MSB_FIRST != 0) ? (sreg << 1) : (sreg >> 1);

   always_comb begin
      state_n = state;
      sreg_n  = sreg;
      cnt_n   = cnt;
      par_n   = par;
      sout_n  = sout;
      sv_n    = sout_valid;
      sof_n   = sof;
      eof_n   = eof;
      if (en) begin
         if (accept) begin
            state_n = SHIFT;
            sreg_n  = load_word;
            cnt_n   = '0;
            par_n   = first_bit;
            sout_n  = first_bit;
            sv_n    = 1'b1;
            sof_n   = 1'b1;
            eof_n   = (FLEN == 1);
         end else if (state == SHIFT) begin
            if (!last) begin
               cnt_n = cnt_inc;
               sof_n = 1'b0;
               eof_n = (cnt_inc == LAST);
               if ((PARITY != 0) && (cnt_inc == LAST)) begin
                  sout_n = par;
               end else begin
                  sout_n = next_bit;
                  sreg_n = shifted;
                  par_n  = par ^ next_bit;
               end
            end else begin
               state_n = IDLE;
               sout_n  = 1'b0;
               sv_n    = 1'b0;
               sof_n   = 1'b0;
               eof_n   = 1'b0;
            end
         end else begin
            sout_n = 1'b0;
            sv_n   = 1'b0;
            sof_n  = 1'b0;
            eof_n  = 1'b0;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         sreg       <= '0;
         cnt        <= '0;
         par        <= 1'b0;
         sout       <= 1'b0;
         sout_valid <= 1'b0;
         sof        <= 1'b0;
         eof        <= 1'b0;
      end else begin
         state      <= state_n;
         sreg       <= sreg_n;
         cnt        <= cnt_n;
         par        <= par_n;
         sout       <= sout_n;
         sout_valid <= sv_n;
         sof        <= sof_n;
         eof        <= eof_n;
      end
   end

endmodule

// File: doc/cb_piso_tx.md
Name: cb_piso_tx

Overview:
Parallel-in, serial-out transmitter. It is the driving end of the single-bit serial path that our enabled, async-reset D flip-flop captures. It accepts a WIDTH-bit word through a valid/ready handshake and shifts it out one bit per enabled clock, with start-of-frame and end-of-frame markers and an optional even-parity bit. It sits in front of any CB flip-flop/shift-register receiver chain and shares that receiver's clk/rst/en conventions.

Parameters:
WIDTH, 8, data word width in bits (2..32)
MSB_FIRST, 1, 1 = transmit bit WIDTH-1 first; 0 = transmit bit 0 first
PARITY, 0, 0 = no parity bit; 1 = append one even-parity bit after the data bits

Ports:
clk  input  1  system clock; all state updates on the rising edge
rst  input  1  asynchronous, active-high reset
en  input  1  clock enable; when 0, all state holds
din  input  WIDTH  parallel word to transmit
load_valid  input  1  din is valid
load_ready  output  1  block can accept din this cycle (combinational)
sout  output  1  serial data bit (registered)
sout_valid  output  1  sout carries a frame bit (registered)
sof  output  1  high with the first bit of a frame (registered)
eof  output  1  high with the last bit of a frame, i.e. the parity bit if PARITY=1 (registered)
busy  output  1  high whenever state is SHIFT

Behaviour:
- One clock (clk). Reset rst is asynchronous and active-high. Frame length is FLEN = WIDTH + PARITY. The bit counter cnt has width clog2(FLEN).
- On reset assertion, with no dependence on clk: state=IDLE; the shift register, cnt and the parity accumulator clear to 0; sout=0, sout_valid=0, sof=0, eof=0, busy=0. Reset asserted mid-frame aborts the frame, and no remaining bits are ever emitted. After rst deasserts, load_ready is high in the first cycle where en=1.
- load_ready = en AND (state==IDLE OR (state==SHIFT AND cnt==FLEN-1)).
- A handshake is accepted on a rising edge where load_valid AND load_ready are both high.
- IDLE:
  - sout_valid=0, sof=0, eof=0, and sout holds 0.
  - On accept: capture din, state->SHIFT, cnt=0.
  - In that same edge, sout=first bit (din[WIDTH-1] if MSB_FIRST, else din[0]), sout_valid=1, sof=1, eof=(FLEN==1, never true for legal WIDTH).
- Latency: the first serial bit is visible in the cycle after the accepting edge.
- SHIFT, on each edge with en=1:
  - If cnt<FLEN-1: cnt+1. sout = next data bit, or the parity bit when cnt+1==WIDTH and PARITY=1. sof=0. eof=(cnt+1==FLEN-1).
  - If cnt==FLEN-1 and an accept occurs (back-to-back): load the new word, cnt=0, sout=its first bit, sof=1, eof=0, and stay in SHIFT. There is no idle gap between frames.
  - If cnt==FLEN-1 and no accept: state->IDLE, sout_valid=0, sof=0, eof=0, sout=0.
- Parity bit = XOR of all WIDTH captured data bits (even parity: data plus parity has an even number of 1s).
- en=0 in any state: shift register, cnt, state and all registered outputs hold their values. load_ready=0, so no accept is possible. A frame stalled mid-way resumes exactly where it left off.
- din is sampled only on the accepting edge. Changes to din during SHIFT have no effect.
- load_valid while load_ready=0 is ignored. The source must hold load_valid until it is accepted.

Test Plan:
1. WIDTH=8, MSB_FIRST=1, PARITY=0, en=1, din=8'hA5 accepted at edge 0 -> over cycles 1..8 sout = 1,0,1,0,0,1,0,1 and sout_valid=1; sof only in cycle 1, eof only in cycle 8; cycle 9 sout_valid=0 and load_ready=1.
2. MSB_FIRST=0, PARITY=1, din=8'h07 -> sout = 1,1,1,0,0,0,0,0 then parity 1 (9 bits); eof on the 9th bit only.
3. Back-to-back: din=8'hF0, then 8'h0F presented with load_valid held -> load_ready=1 in the cycle of bit 8 of the first frame; the second frame's first bit (0, MSB_FIRST=1) follows with no gap; sof high on both frame starts; 16 contiguous sout_valid cycles.
4. en stall: din=8'hC3, drop en for 3 cycles after bit 3 -> sout and sout_valid frozen at bit 3 for 3 cycles, load_ready=0 throughout; transmission resumes with bit 4; total frame 8 valid bits, still 1,1,0,0,0,0,1,1.
5. Reset mid-frame: assert rst asynchronously (not on a clk edge) during bit 5 of 8'hFF -> sout, sout_valid, sof, eof and busy go to 0 immediately; after release, load_ready=1 and no leftover bits appear; a new word 8'h81 transmits cleanly.
6. load_valid asserted during SHIFT with cnt<FLEN-1 -> no accept; the word is taken only at the last-bit cycle.
